// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request in flight against a single-port data memory
// with combinational read; byte/halfword stores are done as read-modify-write.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic            mem_wEn,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_dataWrite,
    input  logic [XLEN-1:0] mem_dataRead
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] word_buf;
    logic [2:0]      funct3_q;
    logic            store_q;

    logic            req_misaligned;
    logic            req_illegal;
    logic            req_bad;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] merged_word;

    // Request legality is judged on the raw inputs so the error path skips memory entirely.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                      || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (req_store) begin
            req_illegal = (req_funct3 >= 3'b011);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110)
                       || (req_funct3 == 3'b111);
        end
        req_bad = req_misaligned || req_illegal;
    end

    // Little-endian lane select and extension of the word currently being read.
    always_comb begin
        rd_byte = mem_dataRead[{addr_q[1:0], 3'b000} +: 8];
        rd_half = mem_dataRead[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            F3_B:    load_value = {{(XLEN-8){rd_byte[7]}}, rd_byte};
            F3_H:    load_value = {{(XLEN-16){rd_half[15]}}, rd_half};
            F3_BU:   load_value = {{(XLEN-8){1'b0}}, rd_byte};
            F3_HU:   load_value = {{(XLEN-16){1'b0}}, rd_half};
            default: load_value = mem_dataRead;
        endcase
    end

    always_comb begin
        merged_word = word_buf;
        if (funct3_q == F3_W) begin
            merged_word = wdata_q;
        end else if (funct3_q == F3_H) begin
            merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    assign req_ready     = (state == IDLE);
    assign mem_wEn       = (state == WR);
    assign mem_address   = ((state == RD) || (state == WR)) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_dataWrite = (state == WR) ? merged_word : '0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    // NOTE: the word buffer is reset too, so a read-modify-write never merges into stale data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_buf   <= '0;
            funct3_q   <= '0;
            store_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        store_q  <= req_store;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else if (req_store && (req_funct3 == F3_W)) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    word_buf <= mem_dataRead;
                    if (store_q) begin
                        state <= WR;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_value;
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a transaction-level model predicts every response and
// memory write; one negedge monitor compares the DUT against it each cycle.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_wEn;
    logic [31:0] mem_address;
    logic [31:0] mem_dataWrite;
    logic [31:0] mem_dataRead;

    load_store_unit #(.XLEN(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mem_wEn       (mem_wEn),
        .mem_address   (mem_address),
        .mem_dataWrite (mem_dataWrite),
        .mem_dataRead  (mem_dataRead)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: 16 words at 0x100..0x13F.
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    assign mem_dataRead = (mem_address[31:6] == 26'h4) ? mem[mem_address[5:2]] : 32'hDEADBEEF;

    always @(posedge clock) begin
        if (reset && mem_wEn && (mem_address[31:6] == 26'h4)) mem[mem_address[5:2]] = mem_dataWrite;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (st) begin
            if (f3 > 3'd2) return 1'b1;
        end else if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
            return 1'b1;
        end
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> (8 * a[1:0]);
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w, input logic [31:0] wd);
        logic [31:0] mask;
        mask = ((f3 == 3'b000) ? 32'hFF : 32'hFFFF) << (8 * a[1:0]);
        return (w & ~mask) | ((wd << (8 * a[1:0])) & mask);
    endfunction

    int          cnt = 0;
    bit          pending = 0;
    bit          m_err, m_has_rd, m_has_wr;
    int          m_acc_cyc, m_rd_cyc, m_wr_cyc, m_resp_cyc;
    logic [31:0] m_word_addr, m_rdata, m_wdata;

    // observed DUT behaviour, for the directed literal checks
    int          acc_count = 0, resp_count = 0, wr_count = 0;
    int          last_lat = 0, last_resp_cyc = 0, prev_resp_cyc = 0;
    logic [31:0] last_rdata, last_wr_addr, last_wr_data;
    logic        last_err;

    always @(negedge clock) begin
        bit idle, exp_rv, exp_we;
        logic [31:0] w;
        cnt++;
        if (!reset) begin
            check("rst_req_ready", req_ready, 1);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_error", resp_error, 0);
            check("rst_resp_rdata", resp_rdata, 0);
            check("rst_mem_wEn", mem_wEn, 0);
            check("rst_mem_address", mem_address, 0);
            check("rst_mem_dataWrite", mem_dataWrite, 0);
            pending = 0;
        end else begin
            idle   = !pending;
            exp_rv = pending && (cnt == m_resp_cyc);
            exp_we = pending && m_has_wr && (cnt == m_wr_cyc);
            check("req_ready", req_ready, idle);
            check("resp_valid", resp_valid, exp_rv);
            check("mem_wEn", mem_wEn, exp_we);
            if (idle || m_err) check("mem_address_zero", mem_address, 0);
            if (pending && ((m_has_rd && cnt == m_rd_cyc) || exp_we))
                check("mem_address", mem_address, m_word_addr);
            if (exp_we) begin
                check("mem_dataWrite", mem_dataWrite, m_wdata);
                ref_mem[m_word_addr[5:2]] = m_wdata;
            end
            if (exp_rv) begin
                check("resp_rdata", resp_rdata, m_rdata);
                check("resp_error", resp_error, m_err);
            end
            if (mem_wEn) begin
                wr_count++;
                last_wr_addr = mem_address;
                last_wr_data = mem_dataWrite;
            end
            if (resp_valid) begin
                resp_count++;
                last_rdata    = resp_rdata;
                last_err      = resp_error;
                last_lat      = cnt - m_acc_cyc;
                prev_resp_cyc = last_resp_cyc;
                last_resp_cyc = cnt;
            end
            if (exp_rv) pending = 0;
            if (idle && req_valid) begin
                acc_count++;
                pending     = 1;
                wr_count    = 0;
                m_acc_cyc   = cnt;
                m_err       = is_bad(req_store, req_funct3, req_addr);
                m_word_addr = {req_addr[31:2], 2'b00};
                w           = ref_mem[req_addr[5:2]];
                m_rdata     = 32'h0;
                m_wdata     = 32'h0;
                m_has_rd    = 0;
                m_has_wr    = 0;
                m_rd_cyc    = cnt + 1;
                if (m_err) begin
                    m_resp_cyc = cnt + 1;
                end else if (!req_store) begin
                    m_has_rd   = 1;
                    m_resp_cyc = cnt + 2;
                    m_rdata    = load_val(req_funct3, req_addr, w);
                end else if (req_funct3 == 3'b010) begin
                    m_has_wr   = 1;
                    m_wr_cyc   = cnt + 1;
                    m_resp_cyc = cnt + 2;
                    m_wdata    = req_wdata;
                end else begin
                    m_has_rd   = 1;
                    m_has_wr   = 1;
                    m_wr_cyc   = cnt + 2;
                    m_resp_cyc = cnt + 3;
                    m_wdata    = merge(req_funct3, req_addr, w, req_wdata);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold);
        int base;
        base       = acc_count;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        for (int i = 0; i < 20 && acc_count == base; i++) begin
            @(posedge clock);
            #1;
        end
        check("accept", acc_count - base, 1);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int base, input int n);
        for (int i = 0; i < 15 && resp_count < base + n; i++) begin
            @(posedge clock);
            #1;
        end
        check("resp_count", resp_count - base, n);
    endtask

    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int exp_wr);
        int r0;
        r0 = resp_count;
        issue(st, f3, a, wd, 1'b0);
        wait_resp(r0, 1);
        check("lit_rdata", last_rdata, exp_rdata);
        check("lit_error", last_err, exp_err);
        check("lit_latency", last_lat, exp_lat);
        check("lit_wr_pulses", wr_count, exp_wr);
    endtask

    initial begin
        int r0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0]     = 32'h8899AABB;
        ref_mem[0] = 32'h8899AABB;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        txn(1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h00008899, 1'b0, 2, 0);
        txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
        txn(1'b1, 3'b000, 32'h103, 32'h12345677, 32'h0, 1'b0, 3, 1);
        check("sb_wr_addr", last_wr_addr, 32'h100);
        check("sb_wr_data", last_wr_data, 32'h7799AABB);
        txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h7799AABB, 1'b0, 2, 0);
        txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0);
        txn(1'b1, 3'b001, 32'h101, 32'hFFFF, 32'h0, 1'b1, 1, 0);
        txn(1'b0, 3'b110, 32'h104, 32'h0, 32'h0, 1'b1, 1, 0);
        check("mem_after_errors", mem[0], 32'h7799AABB);

        // reset while the sh is in RD aborts it
        r0 = resp_count;
        issue(1'b1, 3'b001, 32'h100, 32'h0000CAFE, 1'b0);
        reset = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_mem_wEn", mem_wEn, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("abort_no_resp", resp_count - r0, 0);
        check("abort_mem_kept", mem[0], 32'h7799AABB);

        // back-to-back loads with req_valid held high
        r0 = resp_count;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h104, 32'h0, 1'b0);
        wait_resp(r0, 2);
        check("b2b_spacing", last_resp_cyc - prev_resp_cyc, 3);
        repeat (3) @(posedge clock);
        #1;
        check("b2b_pulses", resp_count - r0, 2);

        for (int k = 0; k < 300; k++) begin
            r0 = resp_count;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'h100 + 32'($urandom_range(0, 63)), $urandom, 1'b0);
            wait_resp(r0, 1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clock);
                #1;
            end
        end

        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
